// File: rtl/can_tx_scheduler.sv
// Transmit-mailbox scheduler in front of can_tx: launches the lowest-ID pending frame and re-queues
// frames that lose arbitration or miss ACK. Optional macro CAN_TX_SCHED_RETRY_LIMIT_EN enables the ack-error drop limit.
module can_tx_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 8,
  localparam int IW       = $clog2(NUM_MB)
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Load,
  input  logic [IW-1:0]     i_Load_Idx,
  input  logic [10:0]       i_Load_Id,
  input  logic [3:0]        i_Load_Dlc,
  input  logic [63:0]       i_Load_Data,
  output logic              o_Load_Err,
  output logic [NUM_MB-1:0] o_Pending,
  input  logic              i_Bus_Idle,
  output logic              o_Tx_Start,
  output logic [10:0]       o_Tx_Id,
  output logic [3:0]        o_Tx_Dlc,
  output logic [63:0]       o_Tx_Data,
  input  logic              i_Tx_Done,
  input  logic              i_Tx_Arb_Lost,
  input  logic              i_Tx_Ack_Err,
  output logic              o_Tx_Ok,
  output logic              o_Tx_Fail,
  output logic [IW-1:0]     o_Tx_Idx
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_START, S_BUSY} state_t;

  state_t state_q, state_d;

  logic [NUM_MB-1:0] valid_q;
  logic [10:0]       id_q   [NUM_MB];
  logic [3:0]        dlc_q  [NUM_MB];
  logic [63:0]       data_q [NUM_MB];

  logic [10:0]   tx_id_q;
  logic [3:0]    tx_dlc_q;
  logic [63:0]   tx_data_q;
  logic [IW-1:0] tx_idx_q;
  logic          ok_q, load_err_q;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [10:0]   win_id;

  logic latch_sel, done_ev, arb_ev, ack_ev, ack_drop, tx_start;
  logic in_flight, load_acc, load_rej;

  function automatic logic [3:0] sat_dlc(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  // Strict less-than keeps the lower index on equal identifiers.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (valid_q[i] && (!win_found || id_q[i] < win_id)) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_id    = id_q[i];
      end
    end
  end

  assign in_flight = ((state_q == S_START) || (state_q == S_BUSY)) && (i_Load_Idx == tx_idx_q);
  assign load_rej  = i_Load && in_flight;
  assign load_acc  = i_Load && !in_flight;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_sel = 1'b0;
    tx_start  = 1'b0;
    done_ev   = 1'b0;
    arb_ev    = 1'b0;
    ack_ev    = 1'b0;
    case (state_q)
      S_IDLE:   if (|valid_q && i_Bus_Idle) state_d = S_SELECT;
      S_SELECT: begin
        latch_sel = win_found;
        state_d   = win_found ? S_START : S_IDLE;
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_BUSY;
      end
      S_BUSY: begin
        if (i_Tx_Done)          done_ev = 1'b1;
        else if (i_Tx_Arb_Lost) arb_ev  = 1'b1;
        else if (i_Tx_Ack_Err)  ack_ev  = 1'b1;
        if (i_Tx_Done || i_Tx_Arb_Lost || i_Tx_Ack_Err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; an arbitration loss needs no action beyond returning to IDLE.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      valid_q    <= '0;
      tx_id_q    <= '0;
      tx_dlc_q   <= '0;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
      ok_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_rej;
      ok_q       <= done_ev;
      if (latch_sel) begin
        tx_idx_q  <= win_idx;
        tx_id_q   <= id_q[win_idx];
        tx_dlc_q  <= dlc_q[win_idx];
        tx_data_q <= data_q[win_idx];
      end
      if (load_acc)            valid_q[i_Load_Idx] <= 1'b1;
      if (done_ev || ack_drop) valid_q[tx_idx_q]   <= 1'b0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (load_acc) begin
      id_q[i_Load_Idx]   <= i_Load_Id;
      dlc_q[i_Load_Idx]  <= sat_dlc(i_Load_Dlc);
      data_q[i_Load_Idx] <= i_Load_Data;
    end
  end

`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
  logic [3:0] retry_q [NUM_MB];
  logic       fail_q;

  assign ack_drop = ack_ev && (({1'b0, retry_q[tx_idx_q]} + 5'd1) >= 5'(MAX_RETRY));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
      fail_q <= 1'b0;
    end else begin
      fail_q <= ack_drop;
      if (load_acc) retry_q[i_Load_Idx] <= '0;
      if (ack_ev)   retry_q[tx_idx_q]   <= retry_q[tx_idx_q] + 4'd1;
    end
  end

  assign o_Tx_Fail = fail_q;
`else
  assign ack_drop  = 1'b0;
  // Without the retry limit MAX_RETRY has no effect and frames are never dropped.
  assign o_Tx_Fail = 1'b0 & (MAX_RETRY != 0);
`endif

  assign o_Load_Err = load_err_q;
  assign o_Pending  = valid_q;
  assign o_Tx_Start = tx_start;
  assign o_Tx_Id    = tx_id_q;
  assign o_Tx_Dlc   = tx_dlc_q;
  assign o_Tx_Data  = tx_data_q;
  assign o_Tx_Idx   = tx_idx_q;
  assign o_Tx_Ok    = ok_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_can_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld;
  logic [1:0]  ld_idx;
  logic [10:0] ld_id;
  logic [3:0]  ld_dlc;
  logic [63:0] ld_data;
  logic        bus_idle, done, arb, ack;
  logic        load_err, tx_start, tx_ok, tx_fail;
  logic [3:0]  pending;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic [1:0]  tx_idx;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_ok = 0, n_fail = 0;

  can_tx_scheduler #(.NUM_MB(4), .MAX_RETRY(3)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Load(ld), .i_Load_Idx(ld_idx), .i_Load_Id(ld_id), .i_Load_Dlc(ld_dlc), .i_Load_Data(ld_data),
    .o_Load_Err(load_err), .o_Pending(pending), .i_Bus_Idle(bus_idle),
    .o_Tx_Start(tx_start), .o_Tx_Id(tx_id), .o_Tx_Dlc(tx_dlc), .o_Tx_Data(tx_data),
    .i_Tx_Done(done), .i_Tx_Arb_Lost(arb), .i_Tx_Ack_Err(ack),
    .o_Tx_Ok(tx_ok), .o_Tx_Fail(tx_fail), .o_Tx_Idx(tx_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (tx_ok)    n_ok++;
    if (tx_fail)  n_fail++;
  end

  typedef struct {
    logic ld; logic [1:0] idx; logic [10:0] id; logic [3:0] dlc;
    logic bus; logic done; logic arb; logic ack;
    logic e_start; logic e_ok; logic e_fail; logic e_lerr;
    logic [3:0] e_pend; logic [10:0] e_id; logic [3:0] e_dlc; logic [1:0] e_idx;
  } vec_t;

  function automatic vec_t V(input logic l, input logic [1:0] ix, input logic [10:0] id,
                             input logic [3:0] dl, input logic bu, input logic dn, input logic ar,
                             input logic ak, input logic st, input logic ok, input logic fl,
                             input logic le, input logic [3:0] pd, input logic [10:0] eid,
                             input logic [3:0] edl, input logic [1:0] eix);
    vec_t v;
    v.ld = l; v.idx = ix; v.id = id; v.dlc = dl; v.bus = bu; v.done = dn; v.arb = ar; v.ack = ak;
    v.e_start = st; v.e_ok = ok; v.e_fail = fl; v.e_lerr = le;
    v.e_pend = pd; v.e_id = eid; v.e_dlc = edl; v.e_idx = eix;
    return v;
  endfunction

  function automatic logic [63:0] mkdata(input logic [10:0] id);
    return 64'hABCD_0000_0000_0000 | {53'd0, id};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    ld = 1'b0; ld_idx = '0; ld_id = '0; ld_dlc = '0; ld_data = '0;
    done = 1'b0; arb = 1'b0; ack = 1'b0;
  endtask

  task automatic load(input logic [1:0] ix, input logic [10:0] id, input logic [3:0] dl,
                      input logic [63:0] d);
    ld = 1'b1; ld_idx = ix; ld_id = id; ld_dlc = dl; ld_data = d;
    tick();
    ld = 1'b0;
  endtask

  task automatic wait_start(input int max_cyc, output bit got);
    got = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!got) begin
        tick();
        if (tx_start) got = 1'b1;
      end
    end
  endtask

  vec_t tbl [22];
  bit   got, stop, last_fail;
  int   launches, s0, f0, o0;
  logic [1:0] last_idx;

  initial begin
    rst = 1'b1; bus_idle = 1'b0;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    chk("reset_pending", pending, 4'b0);
    chk("reset_outputs", {tx_start, tx_ok, tx_fail, load_err, tx_idx, tx_dlc, tx_id}, '0);
    chk("reset_data", tx_data, 64'd0);

    // single frame: start 3 cycles after the load
    tbl[0]  = V(1,0,11'h123,4'd2, 1,0,0,0, 0,0,0,0, 4'b0001, 11'h000,4'd0,0);
    tbl[1]  = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0001, 11'h000,4'd0,0);
    tbl[2]  = V(0,0,11'h000,4'd0, 1,0,0,0, 1,0,0,0, 4'b0001, 11'h123,4'd2,0);
    tbl[3]  = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0001, 11'h123,4'd2,0);
    tbl[4]  = V(0,0,11'h000,4'd0, 1,1,0,0, 0,1,0,0, 4'b0000, 11'h123,4'd2,0);
    tbl[5]  = V(0,0,11'h000,4'd0, 0,0,0,0, 0,0,0,0, 4'b0000, 11'h123,4'd2,0);
    // priority order: mb1 (0x100), mb2 (0x100, DLC 12 clamps to 8), then mb0 (0x300)
    tbl[6]  = V(1,0,11'h300,4'd3, 0,0,0,0, 0,0,0,0, 4'b0001, 11'h123,4'd2,0);
    tbl[7]  = V(1,1,11'h100,4'd4, 0,0,0,0, 0,0,0,0, 4'b0011, 11'h123,4'd2,0);
    tbl[8]  = V(1,2,11'h100,4'd12,0,0,0,0, 0,0,0,0, 4'b0111, 11'h123,4'd2,0);
    tbl[9]  = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0111, 11'h123,4'd2,0);
    tbl[10] = V(0,0,11'h000,4'd0, 1,0,0,0, 1,0,0,0, 4'b0111, 11'h100,4'd4,1);
    tbl[11] = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0111, 11'h100,4'd4,1);
    tbl[12] = V(0,0,11'h000,4'd0, 1,1,0,0, 0,1,0,0, 4'b0101, 11'h100,4'd4,1);
    tbl[13] = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0101, 11'h100,4'd4,1);
    tbl[14] = V(0,0,11'h000,4'd0, 1,0,0,0, 1,0,0,0, 4'b0101, 11'h100,4'd8,2);
    tbl[15] = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0101, 11'h100,4'd8,2);
    tbl[16] = V(0,0,11'h000,4'd0, 1,1,0,0, 0,1,0,0, 4'b0001, 11'h100,4'd8,2);
    tbl[17] = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0001, 11'h100,4'd8,2);
    tbl[18] = V(0,0,11'h000,4'd0, 1,0,0,0, 1,0,0,0, 4'b0001, 11'h300,4'd3,0);
    tbl[19] = V(0,0,11'h000,4'd0, 1,0,0,0, 0,0,0,0, 4'b0001, 11'h300,4'd3,0);
    tbl[20] = V(0,0,11'h000,4'd0, 1,1,0,0, 0,1,0,0, 4'b0000, 11'h300,4'd3,0);
    tbl[21] = V(0,0,11'h000,4'd0, 0,0,0,0, 0,0,0,0, 4'b0000, 11'h300,4'd3,0);

    for (int i = 0; i < 22; i++) begin
      ld = tbl[i].ld; ld_idx = tbl[i].idx; ld_id = tbl[i].id; ld_dlc = tbl[i].dlc;
      ld_data = mkdata(tbl[i].id);
      bus_idle = tbl[i].bus; done = tbl[i].done; arb = tbl[i].arb; ack = tbl[i].ack;
      tick();
      chk($sformatf("v%0d_ctl", i), {tx_start, tx_ok, tx_fail, load_err},
          {tbl[i].e_start, tbl[i].e_ok, tbl[i].e_fail, tbl[i].e_lerr});
      chk($sformatf("v%0d_pend", i), pending, tbl[i].e_pend);
      chk($sformatf("v%0d_frame", i), {tx_idx, tx_dlc, tx_id},
          {tbl[i].e_idx, tbl[i].e_dlc, tbl[i].e_id});
      chk($sformatf("v%0d_data", i), tx_data,
          (tbl[i].e_id == 11'h000) ? 64'd0 : mkdata(tbl[i].e_id));
    end
    idle_inputs();

    // arbitration loss keeps the frame queued until the bus is idle again
    bus_idle = 1'b1;
    f0 = n_fail;
    load(2'd3, 11'h050, 4'd1, mkdata(11'h050));
    wait_start(6, got);
    chk("arb_first_launch", {got, tx_idx, tx_id}, {1'b1, 2'd3, 11'h050});
    tick();
    arb = 1'b1; bus_idle = 1'b0;
    tick();
    arb = 1'b0;
    chk("arb_still_pending", pending, 4'b1000);
    s0 = n_start;
    tick(); tick(); tick();
    chk("arb_no_launch_bus_busy", n_start, s0);
    bus_idle = 1'b1;
    wait_start(6, got);
    chk("arb_relaunch", {got, tx_idx, tx_id}, {1'b1, 2'd3, 11'h050});
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("arb_ok", {tx_ok, tx_idx, pending}, {1'b1, 2'd3, 4'b0000});
    chk("arb_no_fail", n_fail, f0);

    // repeated ack errors
    f0 = n_fail; launches = 0; stop = 1'b0; last_fail = 1'b0; last_idx = '0;
    load(2'd1, 11'h010, 4'd0, mkdata(11'h010));
    for (int k = 0; k < 6; k++) begin
      if (!stop) begin
        wait_start(8, got);
        if (!got) stop = 1'b1;
        else begin
          launches++;
          tick();
          ack = 1'b1;
          tick();
          ack = 1'b0;
          last_fail = tx_fail; last_idx = tx_idx;
        end
      end
    end
`ifdef CAN_TX_SCHED_RETRY_LIMIT_EN
    chk("ack_launch_count", launches, 3);
    chk("ack_fail_pulse", {last_fail, last_idx}, {1'b1, 2'd1});
    chk("ack_fail_count", n_fail - f0, 1);
    chk("ack_dropped", pending, 4'b0000);
`else
    chk("ack_launch_count", launches, 6);
    chk("ack_no_fail", {last_fail, 32'(n_fail - f0)}, 33'd0);
    chk("ack_requeued", pending, 4'b0010);
    wait_start(8, got);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ack_final_ok", {tx_ok, tx_idx, pending}, {1'b1, 2'd1, 4'b0000});
`endif

    // load into the in-flight mailbox is rejected, another mailbox is accepted
    load(2'd0, 11'h200, 4'd5, mkdata(11'h200));
    wait_start(6, got);
    chk("lerr_launch", {got, tx_idx, tx_id}, {1'b1, 2'd0, 11'h200});
    tick();
    load(2'd0, 11'h7FF, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lerr_pulse", load_err, 1'b1);
    chk("lerr_data_held", {tx_data, tx_id}, {mkdata(11'h200), 11'h200});
    load(2'd2, 11'h400, 4'd6, mkdata(11'h400));
    chk("lerr_other_ok", {load_err, pending}, {1'b0, 4'b0101});
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("lerr_done", {tx_ok, tx_idx, pending}, {1'b1, 2'd0, 4'b0100});
    wait_start(6, got);
    chk("lerr_second", {got, tx_idx, tx_dlc, tx_id}, {1'b1, 2'd2, 4'd6, 11'h400});
    chk("lerr_second_data", tx_data, mkdata(11'h400));
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;

    // reset during BUSY abandons the frame; reset wins over a same-cycle load
    load(2'd1, 11'h222, 4'd3, mkdata(11'h222));
    wait_start(6, got);
    tick();
    rst = 1'b1;
    ld = 1'b1; ld_idx = 2'd3; ld_id = 11'h033; ld_dlc = 4'd1; ld_data = mkdata(11'h033);
    tick();
    rst = 1'b0; bus_idle = 1'b0;
    idle_inputs();
    chk("rst_pending", pending, 4'b0000);
    chk("rst_outputs", {tx_start, tx_ok, tx_fail, load_err, tx_idx, tx_dlc, tx_id}, '0);
    chk("rst_data", tx_data, 64'd0);
    o0 = n_ok;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("rst_no_ok", {tx_ok, 32'(n_ok - o0)}, 33'd0);
    chk("rst_load_lost", pending, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Transmit-mailbox scheduler that sits in front of `can_tx`. It holds NUM_MB pending standard-ID data frames and always launches the pending frame with the lowest identifier, mirroring CAN bus priority. It sequences one `can_tx` transaction at a time and re-queues frames that lose arbitration or are not acknowledged. It reports per-frame success or failure to the host logic.

## Interface
Parameters:
- NUM_MB, 4, number of mailboxes (2..8); index width IW = clog2(NUM_MB)
- MAX_RETRY, 8, ack-error retries per frame before drop (1..15)

Ports:
- i_Clock  in  1  system clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Load  in  1  write mailbox i_Load_Idx this cycle
- i_Load_Idx  in  IW  target mailbox
- i_Load_Id  in  11  standard identifier
- i_Load_Dlc  in  4  data length code; values above 8 are stored as 8
- i_Load_Data  in  64  payload, byte 0 in [63:56]
- o_Load_Err  out  1  one-cycle pulse: load rejected
- o_Pending  out  NUM_MB  mailbox-valid flags
- i_Bus_Idle  in  1  `can_tx` and bus idle (interframe space complete)
- o_Tx_Start  out  1  one-cycle launch pulse to `can_tx`
- o_Tx_Id / o_Tx_Dlc / o_Tx_Data  out  11/4/64  frame fields; stable from START until the frame ends
- i_Tx_Done  in  1  pulse: frame sent and acknowledged
- i_Tx_Arb_Lost  in  1  pulse: arbitration lost
- i_Tx_Ack_Err  in  1  pulse: no ACK slot dominant
- o_Tx_Ok  out  1  pulse: frame in mailbox o_Tx_Idx completed
- o_Tx_Fail  out  1  pulse: frame in mailbox o_Tx_Idx dropped after retries
- o_Tx_Idx  out  IW  mailbox of the current or last frame

## Operation
- Each mailbox holds: valid, id, dlc, data, and a 4-bit retry count.
- Load rules:
  - A load to a non-valid mailbox, or to a valid mailbox that is not in flight, overwrites the mailbox, sets valid, and clears its retry count.
  - A load to the in-flight mailbox (states START/BUSY, idx == o_Tx_Idx) is ignored and pulses o_Load_Err.
- FSM states: IDLE, SELECT, START, BUSY.
  - IDLE: if |o_Pending and i_Bus_Idle, go to SELECT.
  - SELECT: latch the winner into o_Tx_Idx and the o_Tx_* fields. The winner is the valid mailbox with the numerically smallest id; on equal ids, the lowest index wins. Go to START.
  - START: o_Tx_Start = 1 for exactly this cycle. Go to BUSY.
  - BUSY: wait for a completion pulse.
    - i_Tx_Done: clear valid, pulse o_Tx_Ok, go to IDLE.
    - i_Tx_Arb_Lost: keep valid, leave retry count unchanged, go to IDLE.
    - i_Tx_Ack_Err: increment the retry count. If the count reaches MAX_RETRY, clear valid and pulse o_Tx_Fail. Otherwise keep valid. Go to IDLE.
- Completion pulses outside BUSY are ignored.
- If several completion pulses arrive in the same cycle, priority is Done > Arb_Lost > Ack_Err.
- Loads arriving during SELECT do not affect the current selection; they are considered at the next SELECT.

## Timing
- Reset values: state IDLE; all valid flags and retry counts 0; every output 0, including o_Tx_Id, o_Tx_Dlc, o_Tx_Data and o_Tx_Idx.
- A load is visible on o_Pending the cycle after i_Load.
- Minimum latency from i_Load (with bus idle, state IDLE) to o_Tx_Start is 3 cycles:
  - load → pending → SELECT → START.
- o_Tx_Ok / o_Tx_Fail are asserted the cycle after the completion pulse and last exactly one cycle. The FSM is back in IDLE in that same cycle.
- Back-to-back frames: at least 2 cycles of IDLE/SELECT separate a completion from the next o_Tx_Start.
- Reset mid-frame: the in-flight frame is abandoned and no Ok/Fail pulse is produced. Reset has priority over i_Load in the same cycle.

## Configuration
- Macro CAN_TX_SCHED_RETRY_LIMIT_EN:
  - Defined: MAX_RETRY and the drop behaviour apply as described in Operation.
  - Not defined: retry counters are not implemented, ack errors always re-queue the frame, and o_Tx_Fail is tied to 0.

## Test plan
- Reset, then load mb0 id=0x123 dlc=2 data=0xABCD..., bus idle → o_Tx_Start 3 cycles after load with o_Tx_Id=0x123, o_Tx_Dlc=2; i_Tx_Done → o_Tx_Ok with o_Tx_Idx=0, o_Pending=0.
- Load mb0 id=0x300, mb1 id=0x100, mb2 id=0x100 → send order is mb1, mb2, mb0, with one o_Tx_Ok per frame.
- Arbitration loss: mb3 id=0x050 in flight, pulse i_Tx_Arb_Lost → mb3 stays pending, is relaunched on the next i_Bus_Idle, and no o_Tx_Fail occurs.
- Ack-error limit with MAX_RETRY=3: answer every launch with i_Tx_Ack_Err → exactly 3 launches, then o_Tx_Fail with o_Tx_Idx correct and valid cleared.
  - With the macro undefined: launches continue indefinitely and o_Tx_Fail stays 0.
- Load to the in-flight mailbox during BUSY → o_Load_Err pulse and o_Tx_Data unchanged. Load to another mailbox in the same window → accepted.
- Assert i_Reset during BUSY → next cycle o_Pending=0, all outputs 0, and a later i_Tx_Done produces no o_Tx_Ok.
